// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with 7-bit address match, byte receive and byte transmit
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       rw,
    output logic       busy,
    output logic       stop_tick
);

    typedef enum logic [2:0] {
        IDLE, ADDR_ST, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] sr;
    logic       sda_oe;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Open-drain: only ever pull low, otherwise leave the line to the pull-up
    assign SDA = sda_oe ? 1'b0 : 1'bz;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & ~sda_s & sda_d;
    assign stop_det  = scl_s & sda_s & ~sda_d;
    assign busy      = (state != IDLE);

    // Two-flop synchronizers plus a delay flop for edge detection; idle bus reads high
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], SCL};
            sda_sync <= {sda_sync[0], SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    // Protocol FSM: bus conditions first, then per-state bit handling on SCL edges
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            sr        <= 8'd0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            rw        <= 1'b0;
            stop_tick <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            stop_tick <= 1'b0;
            if (start_det) begin
                state   <= ADDR_ST;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                bit_cnt   <= 4'd0;
                sda_oe    <= 1'b0;
                stop_tick <= 1'b1;
            end else begin
                case (state)
                    ADDR_ST: begin
                        if (scl_rise) begin
                            sr      <= {sr[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (sr[6:0] == ADDR) begin
                                    rw     <= sda_s;
                                    tx_req <= sda_s;
                                end else begin
                                    state   <= WAIT_STOP;
                                    bit_cnt <= 4'd0;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state   <= ADDR_ACK;
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b1;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                state  <= TX_BYTE;
                                sr     <= tx_data;
                                sda_oe <= ~tx_data[7];
                            end else begin
                                state  <= RX_BYTE;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    RX_BYTE: begin
                        if (scl_rise) begin
                            sr      <= {sr[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= {sr[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state   <= RX_ACK;
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b1;
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            state   <= RX_BYTE;
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                        end
                    end
                    TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                state   <= TX_ACK;
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b0;
                            end else begin
                                sr      <= {sr[6:0], 1'b0};
                                sda_oe  <= ~sr[6];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    TX_ACK: begin
                        // bit_cnt==1 marks that the master ACKed on the 9th rise
                        if (scl_rise) begin
                            if (!sda_s) begin
                                tx_req  <= 1'b1;
                                bit_cnt <= 4'd1;
                            end else begin
                                state   <= WAIT_STOP;
                                bit_cnt <= 4'd0;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state   <= TX_BYTE;
                            bit_cnt <= 4'd0;
                            sr      <= tx_data;
                            sda_oe  <= ~tx_data[7];
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
